// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the serial pattern detector.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      ARMED = 2'd2
   } det_state_t;

   localparam int DEF_MAX_LEN = 8;
   localparam int LEN_W       = $clog2(DEF_MAX_LEN + 1);

   // Bits needed to hold a pattern length of 0..max_len.
   function automatic int len_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping; clear has priority over inc.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pattern_seq_detector.sv
// Runtime-programmable serial pattern recognizer with a Mealy match output,
// optional overlapping matches and a saturating match counter.
//
//   state | meaning
//   IDLE  | no legal configuration loaded; input stream ignored
//   FILL  | collecting the first len-1 bits after a load or a non-overlap match
//   ARMED | history holds len-1 bits; the next valid bit can complete a match
module pattern_seq_detector
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN   = 8,
   parameter int CNT_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_load,
   input  logic [MAX_LEN-1:0]            cfg_pattern,
   input  logic [len_width(MAX_LEN)-1:0] cfg_len,
   input  logic                          cfg_overlap,
   input  logic                          in_valid,
   input  logic                          in_bit,
   output logic                          match,
   output logic [CNT_WIDTH-1:0]          match_count,
   output logic                          armed,
   output logic                          cfg_error
);

   localparam int LW = len_width(MAX_LEN);

   det_state_t         state, state_nxt;
   logic [MAX_LEN-1:0] pat;
   logic [MAX_LEN-1:0] cand;
   logic [MAX_LEN-1:0] mask;
   logic [MAX_LEN-2:0] hist;
   logic [LW-1:0]      len;
   logic [LW-1:0]      fill, fill_nxt, fill_inc;
   logic               overlap;
   logic               len_legal;

   assign len_legal = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
   assign cand      = {hist, in_bit};
   assign fill_inc  = fill + LW'(1);
   assign armed     = (state == ARMED);

   // Only the low len bits of the candidate take part in the compare.
   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++)
         mask[i] = (LW'(i) < len);
   end

   always_comb begin
      match = 1'b0;
      if (!cfg_load && in_valid && (state == ARMED))
         match = (((cand ^ pat) & mask) == '0);
   end

   always_comb begin
      state_nxt = state;
      fill_nxt  = fill;
      if (cfg_load) begin
         fill_nxt = '0;
         if (!len_legal)
            state_nxt = IDLE;
         else if (cfg_len == LW'(1))
            state_nxt = ARMED;
         else
            state_nxt = FILL;
      end else if (in_valid) begin
         unique case (state)
            FILL: begin
               fill_nxt = fill_inc;
               if (fill_inc == (len - LW'(1)))
                  state_nxt = ARMED;
            end
            ARMED: begin
               // Non-overlapping: the completing bit must not seed the next match.
               if (match && !overlap && (len != LW'(1))) begin
                  state_nxt = FILL;
                  fill_nxt  = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pat       <= '0;
         len       <= '0;
         overlap   <= 1'b0;
         hist      <= '0;
         fill      <= '0;
         cfg_error <= 1'b0;
      end else begin
         state <= state_nxt;
         fill  <= fill_nxt;
         if (cfg_load) begin
            hist <= '0;
            if (len_legal) begin
               pat       <= cfg_pattern;
               len       <= cfg_len;
               overlap   <= cfg_overlap;
               cfg_error <= 1'b0;
            end else begin
               pat       <= '0;
               len       <= '0;
               overlap   <= 1'b0;
               cfg_error <= 1'b1;
            end
         end else if (in_valid && (state != IDLE)) begin
            hist <= cand[MAX_LEN-2:0];
         end
      end
   end

   sat_counter #(
      .WIDTH(CNT_WIDTH)
   ) u_match_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cfg_load && len_legal),
      .inc  (match),
      .count(match_count)
   );

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Scoreboard bench: stimulus queues the expected match per valid bit, a negedge monitor compares.
module tb_pattern_seq_detector;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       in_valid;
   logic       in_bit;
   logic       match_a, match_b;
   logic [7:0] count_a;
   logic [1:0] count_b;
   logic       armed_a, armed_b;
   logic       err_a, err_b;

   int   n_vec = 0;
   int   n_err = 0;
   int   beat  = 0;
   logic exp_q[$];
   logic exp_m;

   always #5 clk = ~clk;

   pattern_seq_detector #(.MAX_LEN(8), .CNT_WIDTH(8)) dut_a (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
      .in_bit(in_bit), .match(match_a), .match_count(count_a),
      .armed(armed_a), .cfg_error(err_a));

   pattern_seq_detector #(.MAX_LEN(8), .CNT_WIDTH(2)) dut_b (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
      .in_bit(in_bit), .match(match_b), .match_count(count_b),
      .armed(armed_b), .cfg_error(err_b));

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // A load cycle also carries a valid bit, which must be discarded.
   task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
      cfg_load    = 1'b1;
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      in_valid    = 1'b1;
      in_bit      = 1'b1;
      step();
      cfg_load = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic bit_in(input logic b, input logic exp);
      in_valid = 1'b1;
      in_bit   = b;
      exp_q.push_back(exp);
      step();
      in_valid = 1'b0;
   endtask

   task automatic gap(input logic b);
      in_valid = 1'b0;
      in_bit   = b;
      step();
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && !cfg_load) begin
            beat++;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL scoreboard_empty beat %0d: match_a=%0b, no expectation queued", beat, match_a);
            end else begin
               exp_m = exp_q.pop_front();
               if (match_a !== exp_m || match_b !== exp_m) begin
                  n_err++;
                  $display("FAIL match beat %0d: got a=%0b b=%0b, expected %0b", beat, match_a, match_b, exp_m);
               end
            end
         end else begin
            n_vec++;
            if (match_a !== 1'b0 || match_b !== 1'b0) begin
               n_err++;
               $display("FAIL match_quiet: got a=%0b b=%0b, expected 0 (no valid bit or load)", match_a, match_b);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
      cfg_overlap = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
      step(); step();
      rst = 1'b0;
      check("reset_count", int'(count_a), 0);
      check("reset_armed", int'(armed_a), 0);
      check("reset_cfg_error", int'(err_a), 0);

      // 1) overlapping 1101
      load(8'b0000_1101, 4'd4, 1'b1);
      check("s1_armed_after_load", int'(armed_a), 0);
      bit_in(1, 0); bit_in(1, 0); bit_in(0, 0); bit_in(1, 1);
      bit_in(1, 0); bit_in(0, 0); bit_in(1, 1);
      check("s1_count", int'(count_a), 2);
      check("s1_armed", int'(armed_a), 1);

      // 2) non-overlapping 1101
      load(8'b0000_1101, 4'd4, 1'b0);
      check("s2_count_cleared", int'(count_a), 0);
      bit_in(1, 0); bit_in(1, 0); bit_in(0, 0); bit_in(1, 1);
      check("s2_refill_state", int'(armed_a), 0);
      bit_in(1, 0); bit_in(0, 0); bit_in(1, 0);
      bit_in(1, 0); bit_in(1, 0); bit_in(0, 0); bit_in(1, 1);
      check("s2_count", int'(count_a), 2);

      // 3) single-bit pattern
      load(8'b0000_0001, 4'd1, 1'b0);
      check("s3_armed_after_load", int'(armed_a), 1);
      bit_in(1, 1); bit_in(0, 0); bit_in(1, 1); bit_in(1, 1);
      check("s3_count", int'(count_a), 3);

      // 4) illegal lengths
      load(8'b0000_1101, 4'd0, 1'b1);
      check("s4_cfg_error_len0", int'(err_a), 1);
      check("s4_armed", int'(armed_a), 0);
      check("s4_count_held", int'(count_a), 3);
      bit_in(1, 0); bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(1, 0);
      load(8'b0000_0001, 4'd1, 1'b1);
      check("s4_cfg_error_cleared", int'(err_a), 0);
      load(8'b1111_1111, 4'd9, 1'b1);
      check("s4_cfg_error_len9", int'(err_a), 1);
      check("s4_armed_len9", int'(armed_a), 0);
      bit_in(1, 0); bit_in(1, 0);

      // 5) overlapping 1101 with garbage gaps
      load(8'b0000_1101, 4'd4, 1'b1);
      check("s5_cfg_error_cleared", int'(err_a), 0);
      bit_in(1, 0); gap(1); bit_in(1, 0); gap(0); gap(1);
      bit_in(0, 0); bit_in(1, 1); gap(1); bit_in(1, 0); gap(1);
      bit_in(0, 0); gap(0); bit_in(1, 1); gap(1);
      check("s5_count", int'(count_a), 2);

      // 6) saturation on the 2-bit counter, then reset mid-stream
      load(8'b0000_0001, 4'd1, 1'b1);
      for (int i = 0; i < 5; i++) bit_in(1, 1);
      check("s6_count_sat", int'(count_b), 3);
      check("s6_count_wide", int'(count_a), 5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("s6_rst_count", int'(count_b), 0);
      check("s6_rst_armed", int'(armed_b), 0);
      bit_in(1, 0); bit_in(1, 0);
      check("s6_idle_count", int'(count_b), 0);
      load(8'b0000_0001, 4'd1, 1'b1);
      bit_in(1, 1);
      check("s6_reload_count", int'(count_b), 1);

      step();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
